// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule definitions.
//   word_t / state_t : 32-bit word and 128-bit state/round-key types
//   AES128_ROUNDS    : number of round keys after key 0 for AES-128
//   kexp_state_e     : key expansion FSM states
//   SBOX_TABLE       : forward S-box, entry 0 in the most significant byte
//   rcon()           : round constant for the round key being derived
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  localparam int unsigned AES128_ROUNDS = 10;

  typedef enum logic {IDLE, EMIT} kexp_state_e;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Indexed by the index of the key being expanded from (0..9).
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, single byte, combinational.
//   in_byte  : input byte
//   out_byte : substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry i sits at bit offset 8*(255-i); 255-i is ~i for an 8-bit index.
  always_comb begin
    out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a word in parallel.
//   word_in  : input word
//   word_out : substituted word, same byte positions
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word_in,
  output word_t word_out
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    aes_sbox u_sbox (
      .in_byte  (word_in[8*b +: 8]),
      .out_byte (word_out[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule. Accepts one cipher key, then streams
// round keys 0..NUM_ROUNDS, advancing one key per accepted beat.
//   clk, rst_n           : clock, asynchronous active-low reset
//   key_valid/key_ready  : cipher key handshake (key_in, byte 0 at MSB)
//   rk_valid/rk_ready    : round key handshake (rk_out, rk_idx)
//   done                 : one-cycle pulse after the last round key is taken
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         done
);

  kexp_state_e state_q, state_d;
  state_t      rk_out_q, rk_out_d;
  logic [3:0]  rk_idx_q, rk_idx_d;
  logic        rk_valid_q, rk_valid_d;
  logic        done_q, done_d;

  word_t w0, w1, w2, w3;
  word_t sub_in, sub_out, t;
  word_t n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_out_q;
  assign sub_in = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    t  = sub_out ^ {rcon(rk_idx_q), 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d    = EMIT;
          rk_out_d   = key_in;
          rk_idx_d   = '0;
          rk_valid_d = 1'b1;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (rk_idx_q == 4'(NUM_ROUNDS)) begin
            state_d    = IDLE;
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            rk_out_d = {n0, n1, n2, n3};
            rk_idx_d = rk_idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = rk_valid_q;
  assign rk_out    = rk_out_q;
  assign rk_idx    = rk_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 word-recurrence model with an S-box
// derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid, key_ready, rk_valid, rk_ready, done;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_idx;

  logic         s_key_valid, s_key_ready, s_rk_valid, s_rk_ready, s_done;
  logic [127:0] s_key_in, s_rk_out;
  logic [3:0]   s_rk_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_out(rk_out), .rk_idx(rk_idx), .done(done)
  );

  aes_key_expand #(.NUM_ROUNDS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .key_valid(s_key_valid), .key_ready(s_key_ready),
    .key_in(s_key_in), .rk_valid(s_rk_valid), .rk_ready(s_rk_ready),
    .rk_out(s_rk_out), .rk_idx(s_rk_idx), .done(s_done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_tbl [0:255];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [31:0] sub_rot(input logic [31:0] v);
    logic [31:0] r = {v[23:0], v[31:24]};
    return {sbox_tbl[r[31:24]], sbox_tbl[r[23:16]], sbox_tbl[r[15:8]], sbox_tbl[r[7:0]]};
  endfunction

  // Round key r of the FIPS-197 word recurrence w[i] = w[i-4] ^ temp.
  function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [7:0]  rc = 8'h01;
    logic [31:0] temp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 4*r + 4; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = sub_rot(temp) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- per-cycle monitor (main DUT, NUM_ROUNDS=10) ----------------
  bit           m_busy, m_exp_done, m_stall;
  int           m_idx;
  logic [127:0] m_key, m_prev_out;
  logic [3:0]   m_prev_idx;
  logic [127:0] acc_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_key_ready", 128'(key_ready), 128'(1));
      chk("rst_rk_valid",  128'(rk_valid),  128'(0));
      chk("rst_rk_out",    rk_out,          128'(0));
      chk("rst_rk_idx",    128'(rk_idx),    128'(0));
      chk("rst_done",      128'(done),      128'(0));
      m_busy = 0; m_exp_done = 0; m_stall = 0;
    end else begin
      chk("key_ready", 128'(key_ready), 128'(!m_busy));
      chk("rk_valid",  128'(rk_valid),  128'(m_busy));
      chk("done",      128'(done),      128'(m_exp_done));
      if (m_busy) begin
        chk("rk_idx", 128'(rk_idx), 128'(m_idx));
        chk("rk_out", rk_out, model_rk(m_key, m_idx));
        if (m_stall) begin
          chk("stall_out", rk_out, m_prev_out);
          chk("stall_idx", 128'(rk_idx), 128'(m_prev_idx));
        end
      end
      m_exp_done = 0;
      m_stall = 0;
      if (m_busy) begin
        if (rk_ready) begin
          acc_q.push_back(rk_out);
          if (m_idx == 10) begin
            m_busy = 0;
            m_exp_done = 1;
          end else m_idx++;
        end else begin
          m_stall = 1;
          m_prev_out = rk_out;
          m_prev_idx = rk_idx;
        end
      end else if (key_valid) begin
        m_key = key_in;
        m_idx = 0;
        m_busy = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_key(input logic [127:0] key, input bit rand_ready, input bit excl,
                         input logic [127:0] key2, output int valid_cycles, output bit got_done);
    @(posedge clk); #1;
    key_in = key;
    key_valid = 1'b1;
    rk_ready = 1'b1;
    @(posedge clk); #1;
    if (excl) key_in = key2;
    else key_valid = 1'b0;
    valid_cycles = 0;
    got_done = 0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rk_valid) valid_cycles++;
      if (done) got_done = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  logic [127:0] ref_q [$];
  int           vc;
  bit           gd, hit, any_done;
  logic [127:0] k2;
  int           n3;
  logic [127:0] last3;
  logic [3:0]   last3_idx;

  initial begin
    rst_n = 1'b0;
    key_valid = 1'b0; key_in = '0; rk_ready = 1'b0;
    s_key_valid = 1'b0; s_key_in = '0; s_rk_ready = 1'b0;
    #1;
    chk("model_sbox00", 128'(sbox_tbl[0]), 128'h63);
    chk("model_sbox53", 128'(sbox_tbl[8'h53]), 128'hed);
    chk("model_fips1",  model_rk(FIPS_KEY, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips10", model_rk(FIPS_KEY, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_zero2",  model_rk('0, 2), 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_key_ready", 128'(key_ready), 128'(1));
    chk("reset_rk_valid",  128'(rk_valid),  128'(0));
    chk("reset_rk_out",    rk_out,          128'(0));
    chk("reset_done",      128'(done),      128'(0));
    rst_n = 1'b1;

    // FIPS key, constant ready
    acc_q.delete();
    run_key(FIPS_KEY, 0, 0, '0, vc, gd);
    chk("fips_valid_cycles", 128'(vc), 128'(11));
    chk("fips_done", 128'(gd), 128'(1));
    chk("fips_count", 128'(acc_q.size()), 128'(11));
    if (acc_q.size() == 11) begin
      chk("fips_rk0",  acc_q[0],  FIPS_KEY);
      chk("fips_rk1",  acc_q[1],  128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips_rk10", acc_q[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    end
    ref_q = acc_q;

    // all-zero key
    acc_q.delete();
    run_key('0, 0, 0, '0, vc, gd);
    chk("zero_done", 128'(gd), 128'(1));
    if (acc_q.size() >= 3) begin
      chk("zero_rk1", acc_q[1], 128'h62636363626363636263636362636363);
      chk("zero_rk2", acc_q[2], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    end else chk("zero_count", 128'(acc_q.size()), 128'(11));

    // backpressure
    acc_q.delete();
    run_key(FIPS_KEY, 1, 0, '0, vc, gd);
    chk("bp_done", 128'(gd), 128'(1));
    chk("bp_count", 128'(acc_q.size()), 128'(11));
    for (int i = 0; i < 11 && i < acc_q.size(); i++) chk("bp_seq", acc_q[i], ref_q[i]);

    // key_valid held with another key through EMIT
    acc_q.delete();
    k2 = {$urandom, $urandom, $urandom, $urandom};
    run_key(FIPS_KEY, 0, 1, k2, vc, gd);
    chk("excl_done", 128'(gd), 128'(1));
    for (int i = 0; i < 11 && i < acc_q.size(); i++) chk("excl_seq", acc_q[i], ref_q[i]);
    @(negedge clk);
    chk("excl_k2_valid", 128'(rk_valid), 128'(1));
    chk("excl_k2_idx",   128'(rk_idx),   128'(0));
    chk("excl_k2_out",   rk_out,         k2);
    gd = 0;
    for (int c = 0; c < 40 && !gd; c++) begin
      @(negedge clk);
      if (done) gd = 1;
    end
    chk("excl_k2_done", 128'(gd), 128'(1));

    // reset mid-stream at rk_idx 4
    @(posedge clk); #1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    rk_ready = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (rk_valid && rk_idx == 4'd4) hit = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("rst_reached_idx4", 128'(hit), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rk_valid",  128'(rk_valid),  128'(0));
    chk("async_rk_out",    rk_out,          128'(0));
    chk("async_rk_idx",    128'(rk_idx),    128'(0));
    chk("async_key_ready", 128'(key_ready), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    any_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) any_done = 1;
    end
    chk("rst_no_done", 128'(any_done), 128'(0));
    acc_q.delete();
    k2 = {$urandom, $urandom, $urandom, $urandom};
    run_key(k2, 0, 0, '0, vc, gd);
    chk("rst_restart_done", 128'(gd), 128'(1));
    chk("rst_restart_count", 128'(acc_q.size()), 128'(11));
    if (acc_q.size() > 0) chk("rst_restart_rk0", acc_q[0], k2);

    // NUM_ROUNDS=3 instance
    @(posedge clk); #1;
    s_key_in = FIPS_KEY;
    s_key_valid = 1'b1;
    s_rk_ready = 1'b1;
    @(posedge clk); #1;
    s_key_valid = 1'b0;
    n3 = 0; gd = 0; last3 = '0; last3_idx = '0;
    for (int c = 0; c < 50 && !gd; c++) begin
      @(negedge clk);
      if (s_rk_valid) begin
        n3++;
        last3 = s_rk_out;
        last3_idx = s_rk_idx;
        chk("r3_rk_out", s_rk_out, model_rk(FIPS_KEY, int'(s_rk_idx)));
      end
      if (s_done) gd = 1;
      @(posedge clk); #1;
    end
    chk("r3_count", 128'(n3), 128'(4));
    chk("r3_last_idx", 128'(last3_idx), 128'(3));
    chk("r3_last_rk", last3, 128'h3d80477d4716fe3e1e237e446d7a883b);
    chk("r3_done", 128'(gd), 128'(1));

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
